// File: rtl/coef_bank_pkg.sv
// Shared types and constants for the coefficient bank sequencer.
// Optional macro COEF_SHADOW_EN adds the WAIT_TICK state used by the shadow-swap build.
package coef_bank_pkg;

  localparam int ROM_BANDS = 4;
  localparam int ROM_COEF  = 5;
  localparam int ROM_W     = 32;

  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef COEF_SHADOW_EN
    ST_WAIT_TICK = 2'd2,
`endif
    ST_LOAD = 2'd1
  } state_t;

  // Raw words wider than WIDTH are truncated at lookup; band 0 stays all-zero.
  localparam logic [ROM_W-1:0] COEF_ROM [ROM_BANDS][ROM_COEF] = '{
    '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'h0000_0001, 32'h0000_0003, 32'h0000_0007, 32'h007F_FFF0, 32'h0000_000F},
    '{32'h0000_0123, 32'h0000_0246, 32'h0000_0552, 32'h007F_F001, 32'h0000_0ABC},
    '{32'h0000_1A05, 32'h0000_280A, 32'h0000_340B, 32'h007C_1234, 32'h01AB_CDEF}
  };

endpackage

// File: rtl/coef_bank_seq_rom.sv
// Combinational (band, index) to coefficient word lookup.
// Bands or indices outside the table read as zero.
module coef_rom
  import coef_bank_pkg::*;
#(
  parameter int WIDTH    = 23,
  parameter int NUM_COEF = 5,
  parameter int NBANDS   = 4,
  parameter int SEL_W    = 2,
  parameter int IDX_W    = 3
) (
  input  logic [SEL_W-1:0] band,
  input  logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] word
);

  always_comb begin
    word = '0;
    for (int b = 0; b < ROM_BANDS; b++) begin
      for (int k = 0; k < ROM_COEF; k++) begin
        if (b < NBANDS && k < NUM_COEF && int'(band) == b && int'(index) == k) begin
          word = WIDTH'(COEF_ROM[b][k]);
        end
      end
    end
  end

endmodule

// File: rtl/coef_bank_seq.sv
// Coefficient bank sequencer: loads one ROM set per request into the active bus.
// Macro COEF_SHADOW_EN loads a shadow set first and swaps it in on sample_tick.
//
// state      | meaning
// IDLE       | ready for a request, bus holds the last completed set
// LOAD       | writing one word per cycle, index 0..NUM_COEF-1
// WAIT_TICK  | shadow full, waiting for sample_tick to swap (shadow build only)
module coef_bank_seq
  import coef_bank_pkg::*;
#(
  parameter int WIDTH    = 23,
  parameter int NUM_COEF = 5,
  parameter int NBANDS   = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sample_tick,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [SEL_W-1:0]          cur_sel,
  output logic [NUM_COEF*WIDTH-1:0] coef_bus
);

  localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q;
  logic [SEL_W-1:0]                 tgt_q;
  logic [SEL_W-1:0]                 cur_sel_q;
  logic                             done_q;
  logic [NUM_COEF-1:0][WIDTH-1:0]   coef_q;
  logic [WIDTH-1:0]                 rom_word;
  logic                             last_word;

`ifdef COEF_SHADOW_EN
  logic [NUM_COEF-1:0][WIDTH-1:0]   shadow_q;
`else
  logic                             tick_unused;
  assign tick_unused = sample_tick;
`endif

  coef_rom #(
    .WIDTH   (WIDTH),
    .NUM_COEF(NUM_COEF),
    .NBANDS  (NBANDS),
    .SEL_W   (SEL_W),
    .IDX_W   (IDX_W)
  ) u_rom (
    .band (tgt_q),
    .index(idx_q),
    .word (rom_word)
  );

  assign last_word = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_LOAD;
      ST_LOAD: begin
        if (last_word) begin
`ifdef COEF_SHADOW_EN
          state_d = ST_WAIT_TICK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef COEF_SHADOW_EN
      ST_WAIT_TICK: if (sample_tick) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      tgt_q     <= '0;
      cur_sel_q <= '0;
      done_q    <= 1'b0;
      coef_q    <= '0;
`ifdef COEF_SHADOW_EN
      shadow_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            tgt_q <= sel;
            idx_q <= '0;
          end
        end
        ST_LOAD: begin
`ifdef COEF_SHADOW_EN
          shadow_q[idx_q] <= rom_word;
`else
          coef_q[idx_q] <= rom_word;
`endif
          if (last_word) begin
            idx_q <= '0;
`ifndef COEF_SHADOW_EN
            cur_sel_q <= tgt_q;
            done_q    <= 1'b1;
`endif
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
`ifdef COEF_SHADOW_EN
        // Whole-set copy in one edge keeps the bus consistent within a sample period.
        ST_WAIT_TICK: begin
          if (sample_tick) begin
            coef_q    <= shadow_q;
            cur_sel_q <= tgt_q;
            done_q    <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cur_sel  = cur_sel_q;
  assign coef_bus = coef_q;

endmodule

// File: doc/coef_bank_seq.md
COEF_BANK_SEQ -- requirements
Module: coef_bank_seq

Interface
REQ-001 Parameter WIDTH, default 23: bit width of each coefficient word.
REQ-002 Parameter NUM_COEF, default 5: coefficients per set, index order b0,b1,b2,a1,a2.
REQ-003 Parameter NBANDS, default 4: selectable sets; band 0 is the all-zero set.
REQ-004 Parameter SEL_W, default 2: select width, equal to ceil(log2(NBANDS)).
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  load request, qualified by ready.
REQ-008 sel  input  SEL_W  band index, sampled when req and ready are both high.
REQ-009 sample_tick  input  1  one-cycle filter sample strobe.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a new set becomes active.
REQ-013 cur_sel  output  SEL_W  band currently active on coef_bus.
REQ-014 coef_bus  output  NUM_COEF*WIDTH  active coefficients, registered; index k occupies bits [k*WIDTH +: WIDTH].

Function
REQ-015 Source data is a constant ROM of NBANDS x NUM_COEF words; each word is zero-extended or truncated to WIDTH.
REQ-016 FSM states: IDLE, LOAD, WAIT_TICK (WAIT_TICK exists only under the macro in REQ-027).
REQ-017 Transition IDLE to LOAD on the cycle where req and ready are both high; sel is latched into a target register.
REQ-018 A req while ready is low is ignored and not queued.
REQ-019 LOAD writes one word per cycle, index 0 through NUM_COEF-1, so it lasts exactly NUM_COEF cycles.
REQ-020 Without the shadow macro, LOAD writes the active registers directly; after the last write the FSM returns to IDLE, done pulses, and cur_sel updates in that same cycle.
REQ-021 Accept-to-done latency is NUM_COEF+1 cycles when no shadow buffer is compiled in.
REQ-022 A sel value of NBANDS or greater loads all zeros, and cur_sel takes the requested value.
REQ-023 A request for the band already in cur_sel is still performed in full: full LOAD sequence and a done pulse.
REQ-024 coef_bus and cur_sel never change outside LOAD (no macro) or outside the swap cycle (with macro).

Reset
REQ-025 While rst_n is low: FSM goes to IDLE, coef_bus=0, cur_sel=0, done=0, busy=0, ready=1, and shadow registers and the index counter clear.
REQ-026 Reset asserted mid-LOAD or mid-WAIT_TICK aborts the load; no done pulse follows, and the first cycle after release is IDLE.

Configuration
REQ-027 Macro COEF_SHADOW_EN, when defined, adds a shadow set.
REQ-028 With COEF_SHADOW_EN: LOAD writes only the shadow set, then the FSM enters WAIT_TICK; the first sample_tick seen in WAIT_TICK copies shadow to active in one cycle, pulses done, updates cur_sel, and returns to IDLE.
REQ-029 With COEF_SHADOW_EN, a sample_tick during LOAD or on the LOAD-exit cycle does not swap; coef_bus stays glitch-free across a sample period.
REQ-030 Without COEF_SHADOW_EN: no shadow storage, no WAIT_TICK state, and sample_tick is unused.

Structure
REQ-031 Package coef_bank_pkg holds: the ROM table constant, the FSM state encoding, and coefficient index constants (B0, B1, B2, A1, A2).
REQ-032 One sub-module, coef_rom: combinational (band, index) to word lookup; the FSM and registers remain in coef_bank_seq.

Verification
REQ-033 Reset, then req with sel=1 (no macro) -> done 6 cycles after accept; the b2 slice equals 0x000007; cur_sel=1.
REQ-034 req with sel=3, then req pulsed during busy -> the second request is dropped; the b2 slice equals 0x00340B; exactly one done pulse.
REQ-035 sel=2 with COEF_SHADOW_EN, tick held off for 20 cycles -> coef_bus unchanged until the tick; swap on the tick; b2 slice equals 0x000552.
REQ-036 rst_n dropped on the 3rd LOAD cycle -> coef_bus=0, no done pulse, ready=1 after release.
REQ-037 req with sel=0 after band 3 is active -> all slices equal 0; cur_sel=0; done pulses once.
